// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: active-low segment patterns {g..a} and decoded codes shared with the display encoder
package sevenseg_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;
endpackage

// File: rtl/sevenseg_pattern_decode.sv
// sevenseg_pattern_decode: maps an active-low segment pattern back to its digit code
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);
  always_comb begin
    bad = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_BAD;
        bad  = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: rebuilds the four displayed digits from multiplexed an/seg/dp scan lines
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic        frame_valid,
  output logic        frame_stb,
  output logic        bad_pattern,
  output logic        err_multi_an
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [3:0]    an_q, mask, mask_n, slot_p, frame_p;
  logic [15:0]   slot_d, frame_d;
  logic [19:0]   cand;
  logic [CW-1:0] settle;
  logic [SW-1:0] stable, stable_n;
  logic [TW-1:0] timer;
  logic [3:0]    code;
  logic          bad, multi, sample, complete, publish, timeout;
  sevenseg_pattern_decode u_dec (.seg(seg), .code(code), .bad(bad));
  // an is compared against an_q so a sample never lands on the edge where the digit switches
  always_comb begin
    multi    = |(~an_q & (~an_q - 4'd1));
    sample   = an_q != 4'hF && !multi && an == an_q && settle == CW'(SETTLE_CYCLES - 1);
    frame_d  = slot_d;
    frame_p  = slot_p;
    for (int i = 0; i < 4; i++) begin
      frame_d[4*i +: 4] = sample && !an_q[i] ? code : slot_d[4*i +: 4];
      frame_p[i]        = sample && !an_q[i] ? ~dp : slot_p[i];
    end
    mask_n   = mask | (sample ? ~an_q : 4'h0);
    complete = mask_n == 4'hF;
    stable_n = {frame_d, frame_p} != cand ? SW'(1) :
               stable == SW'(STABLE_FRAMES) ? stable : stable + SW'(1);
    publish  = complete && stable_n == SW'(STABLE_FRAMES);
    timeout  = !complete && timer == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= 4'hF;
      settle       <= '0;
      mask         <= '0;
      slot_d       <= '0;
      slot_p       <= '0;
      cand         <= '0;
      stable       <= '0;
      timer        <= '0;
      digits       <= {4{CODE_BLANK}};
      dps          <= '0;
      frame_valid  <= 1'b0;
      frame_stb    <= 1'b0;
      bad_pattern  <= 1'b0;
      err_multi_an <= 1'b0;
    end else begin
      an_q         <= an;
      settle       <= an != an_q || multi ? '0 :
                      settle == CW'(SETTLE_CYCLES) ? settle : settle + CW'(1);
      slot_d       <= frame_d;
      slot_p       <= frame_p;
      mask         <= complete || timeout ? 4'h0 : mask_n;
      timer        <= complete ? '0 : timer == TW'(TIMEOUT_CYCLES) ? timer : timer + TW'(1);
      cand         <= complete ? {frame_d, frame_p} : cand;
      stable       <= complete ? stable_n : timeout ? '0 : stable;
      digits       <= publish ? frame_d : digits;
      dps          <= publish ? frame_p : dps;
      frame_valid  <= publish ? 1'b1 : timeout ? 1'b0 : frame_valid;
      frame_stb    <= publish && ({frame_d, frame_p} != {digits, dps} || !frame_valid);
      bad_pattern  <= sample && bad;
      err_multi_an <= multi;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder: directed scan sequences with hand-computed digits, pulse counts and timeout timing
module tb_sevenseg_scan_decoder;
  localparam int TO = 200;
  logic        clk = 1'b0, rst = 1'b1, dp = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic        frame_valid, frame_stb, bad_pattern, err_multi_an;
  int          n_stb = 0, n_bad = 0, n_multi = 0, checks = 0, passed = 0, b_stb, b_bad, b_multi;
  sevenseg_scan_decoder #(.SETTLE_CYCLES(4), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp), .digits(digits), .dps(dps),
    .frame_valid(frame_valid), .frame_stb(frame_stb), .bad_pattern(bad_pattern),
    .err_multi_an(err_multi_an)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_stb) n_stb++;
    if (bad_pattern) n_bad++;
    if (err_multi_an) n_multi++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'b1000000;
      4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;
      4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;
      4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;
      4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0010000;
      4'hE: pat = 7'b0101010;
      default: pat = 7'b1111111;
    endcase
  endfunction
  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic p, input int n, input int glitch);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      an  = a;
      seg = i < glitch ? 7'b0000000 : s;
      dp  = p;
    end
  endtask
  task automatic frame(input logic [15:0] d, input logic [3:0] dpm, input int glitch);
    for (int k = 3; k >= 0; k--) show(~(4'b0001 << k), pat(d[4*k +: 4]), ~dpm[k], 16, glitch);
  endtask
  task automatic base();
    b_stb = n_stb;
    b_bad = n_bad;
    b_multi = n_multi;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    show(4'b0111, pat(4'd5), 1'b0, 16, 0);
    show(4'b1011, pat(4'd6), 1'b1, 8, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digits", digits, 16'hFFFF);
    check("rst_dps", dps, 4'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_pulses", {frame_stb, bad_pattern, err_multi_an}, 3'b000);
    #1 rst = 1'b0;
    base();
    repeat (2) frame(16'h1234, 4'b0010, 0);
    check("pub_stb", n_stb - b_stb, 1);
    check("pub_digits", digits, 16'h1234);
    check("pub_dps", dps, 4'b0010);
    check("pub_valid", frame_valid, 1'b1);
    repeat (2) frame(16'h1234, 4'b0010, 0);
    check("steady_no_stb", n_stb - b_stb, 1);
    base();
    frame(16'h1237, 4'b0010, 0);
    check("chg1_digits", digits, 16'h1234);
    check("chg1_stb", n_stb - b_stb, 0);
    frame(16'h1237, 4'b0010, 0);
    check("chg2_digits", digits, 16'h1237);
    check("chg2_stb", n_stb - b_stb, 1);
    repeat (2) frame(16'h1234, 4'b0010, 0);
    check("restore_digits", digits, 16'h1234);
    base();
    repeat (2) frame(16'h1234, 4'b0010, 2);
    check("glitch_digits", digits, 16'h1234);
    check("glitch_stb", n_stb - b_stb, 0);
    check("glitch_bad", n_bad - b_bad, 0);
    show(4'b0111, pat(4'd1), 1'b1, 16, 0);
    show(4'b1011, pat(4'd2), 1'b1, 16, 0);
    show(4'b1101, pat(4'd3), 1'b0, 16, 0);
    show(4'b1110, pat(4'd4), 1'b1, 1, 0);
    repeat (TO + 4) @(posedge clk);
    @(negedge clk);
    check("to_before", frame_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("to_after", frame_valid, 1'b0);
    check("to_hold", digits, 16'h1234);
    check("to_hold_dps", dps, 4'b0010);
    base();
    for (int f = 0; f < 2; f++) begin
      show(4'b0111, pat(4'd1), 1'b1, 16, 0);
      show(4'b1011, pat(4'hE), 1'b1, 16, 0);
      show(4'b1100, pat(4'd8), 1'b0, 8, 0);
      show(4'b1101, pat(4'd3), 1'b1, 16, 0);
      show(4'b1110, pat(4'd4), 1'b1, 16, 0);
    end
    check("multi_pulses", n_multi - b_multi, 16);
    check("bad_pulses", n_bad - b_bad, 2);
    check("bad_digits", digits, 16'h1E34);
    check("bad_dps", dps, 4'b0000);
    check("bad_valid", frame_valid, 1'b1);
    check("bad_stb", n_stb - b_stb, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
